echo_responder: RTL and testbench
=================================

Name: echo_responder

Overview:
- Consumer stage directly downstream of the one-entry request FIFO in the echo path.
- Pops 32-bit request words through the FIFO's first/deq guarded methods.
- Holds each word for a programmable number of cycles, then delivers it to the indication port with a rolling sequence tag.
- Tracks the total echoed-message count; applies back-pressure to the FIFO while the indication side is stalled.

Parameters:
- SEQ_W, 8, width of the sequence tag; wraps modulo 2^SEQ_W.
- DELAY_W, 4, width of the cfg_delay field and the internal countdown.
- CNT_W, 16, width of the echoed-message counter; saturates.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  reset, synchronous and active-high.
- in_first__RDY  input  1  upstream FIFO holds a word.
- in_first  input  32  upstream FIFO head word.
- in_deq__RDY  input  1  upstream FIFO deq method enabled.
- in_deq__ENA  output  1  pop strobe to upstream FIFO; one cycle per word.
- cfg_delay  input  DELAY_W  hold cycles between capture and eligibility to send.
- ind_heard__RDY  input  1  indication sink can accept.
- ind_heard__ENA  output  1  indication fires this cycle.
- ind_heard_v  output  32  echoed word.
- ind_heard_seq  output  SEQ_W  sequence tag of the echoed word.
- count  output  CNT_W  number of indications fired, saturating.
- busy  output  1  high when not IDLE.

Behaviour:
- States: IDLE, HOLD, SEND. Registers: data_reg[31:0], seq_reg, cnt_reg, dly_cnt.
- Reset (RST high at an edge): state=IDLE; data_reg=0, seq_reg=0, cnt_reg=0, dly_cnt=0. All outputs are driven from state, so ENA outputs are 0 and busy=0 during and after reset.
- Reset mid-operation: any word held in HOLD/SEND is discarded and never indicated; it has already been popped.
- While RST is high, in_deq__ENA and ind_heard__ENA are forced to 0 combinationally.
- take = in_first__RDY & in_deq__RDY & (state==IDLE | fire). in_deq__ENA = take, combinational, same cycle.
- fire = (state==SEND) & ind_heard__RDY. ind_heard__ENA = fire.
- Capture on take: data_reg<=in_first; dly_cnt<=cfg_delay. Next state is SEND if cfg_delay==0, else HOLD.
- cfg_delay is sampled only at capture; later changes do not affect a word in flight.
- HOLD: dly_cnt decrements each cycle; at dly_cnt==1 the next state is SEND. Total HOLD residency = cfg_delay cycles.
- SEND: ind_heard_v=data_reg and ind_heard_seq=seq_reg, both stable until fire.
- On fire: seq_reg<=seq_reg+1 (wraps 2^SEQ_W-1 -> 0); cnt_reg<=cnt_reg+1 unless all-ones (saturate). Next state is IDLE, or capture of the next word if take is also high in the same cycle.
- Latency: word captured at cycle t -> earliest ind_heard__ENA at cycle t+1+cfg_delay.
- Throughput: with cfg_delay=0 and ind_heard__RDY held high, one word per cycle.
- Back-pressure: SEND with ind_heard__RDY=0 -> no fire, no take, all registers hold; the upstream FIFO stays full.
- ind_heard_v/ind_heard_seq outside SEND show the last register values and are don't-care to the sink.
- count = cnt_reg; busy = (state!=IDLE).
- No X propagation: ENA outputs are never X after the first reset edge.

Test Plan:
- Reset, FIFO presents 0xDEADBEEF, cfg_delay=0, sink RDY=1 -> in_deq__ENA=1 at cycle 0; ind_heard__ENA=1 at cycle 1 with v=0xDEADBEEF, seq=0; count=1 at cycle 2.
- cfg_delay=3, word 0x00000011 captured at cycle 0 -> busy=1 cycles 1..4; ind_heard__ENA first high at cycle 4; no second deq before then; changing cfg_delay to 0 at cycle 1 has no effect.
- Sink RDY=0 for 5 cycles while in SEND with word 0xA5A5A5A5 -> ENA stays 0, v/seq stable, in_deq__ENA=0 despite FIFO ready; RDY=1 at cycle 6 -> exactly one fire, count increments by 1.
- Words 1,2,3 available back-to-back, cfg_delay=0, RDY=1 -> heard on three consecutive cycles with v=1,2,3 and seq=0,1,2; in_deq__ENA high on each fire cycle.
- 257 messages with SEQ_W=8 -> seq runs 0..255, then 0 on message 257; count=257. With CNT_W=4, count holds at 15 after message 15.
- RST asserted in HOLD (cfg_delay=5, after 2 cycles) -> no indication for that word; state IDLE, seq=0, count=0 next cycle; the next word echoes with seq=0.

Source files
------------

// File: rtl/echo_responder_if.sv
// Handshake bundle between the echo responder, its upstream request FIFO and the indication sink.
// The slave side is the responder; the master side is the FIFO/sink environment.
interface echo_responder_if #(
  parameter int SEQ_W = 8
);
  logic              in_first__RDY;
  logic [31:0]       in_first;
  logic              in_deq__RDY;
  logic              in_deq__ENA;
  logic              ind_heard__RDY;
  logic              ind_heard__ENA;
  logic [31:0]       ind_heard_v;
  logic [SEQ_W-1:0]  ind_heard_seq;

  modport master (
    output in_first__RDY, in_first, in_deq__RDY, ind_heard__RDY,
    input  in_deq__ENA, ind_heard__ENA, ind_heard_v, ind_heard_seq
  );

  modport slave (
    input  in_first__RDY, in_first, in_deq__RDY, ind_heard__RDY,
    output in_deq__ENA, ind_heard__ENA, ind_heard_v, ind_heard_seq
  );
endinterface

// File: rtl/echo_responder.sv
// Pops request words from the upstream FIFO, holds each for cfg_delay cycles and echoes it
// to the indication port with a rolling sequence tag and a saturating message count.
module echo_responder #(
  parameter int SEQ_W   = 8,
  parameter int DELAY_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  echo_responder_if.slave    bus,
  input  logic [DELAY_W-1:0] cfg_delay,
  output logic [CNT_W-1:0]   count,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SEND
  } state_e;

  state_e             state_q;
  logic [31:0]        data_q;
  logic [SEQ_W-1:0]   seq_q;
  logic [SEQ_W-1:0]   seq_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [DELAY_W-1:0] dly_q;
  logic [DELAY_W-1:0] dly_d;
  logic               take;
  logic               fire;

  // A new word may be popped in the same cycle the held word fires, which gives full throughput.
  always_comb begin
    fire  = (state_q == SEND) && bus.ind_heard__RDY && !RST;
    take  = bus.in_first__RDY && bus.in_deq__RDY && ((state_q == IDLE) || fire) && !RST;
    seq_d = seq_q + SEQ_W'(1);
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    dly_d = dly_q - DELAY_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      seq_q   <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
    end else begin
      if (fire) begin
        seq_q <= seq_d;
        cnt_q <= cnt_d;
      end
      if (take) begin
        data_q  <= bus.in_first;
        dly_q   <= cfg_delay;
        state_q <= (cfg_delay == '0) ? SEND : HOLD;
      end else begin
        case (state_q)
          // HOLD is entered only with a nonzero delay, so the count reaches 1 before it could wrap.
          HOLD: begin
            dly_q <= dly_d;
            if (dly_q == DELAY_W'(1)) begin
              state_q <= SEND;
            end
          end
          SEND: begin
            if (fire) begin
              state_q <= IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_deq__ENA    = take;
  assign bus.ind_heard__ENA = fire;
  assign bus.ind_heard_v    = data_q;
  assign bus.ind_heard_seq  = seq_q;
  assign count              = cnt_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_echo_responder.sv
// Directed bench for echo_responder: a scoreboard queue holds expected {word, seq} pairs and a
// negedge monitor pops one per indication; a second instance with a 4-bit counter covers saturation.
module tb_echo_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  cfgDelay;
  logic [15:0] count;
  logic [3:0]  count4;
  logic        busy;
  logic        busy4;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] sbQ[$];
  logic [7:0]  expSeq;

  echo_responder_if #(.SEQ_W(8)) ifc ();
  echo_responder_if #(.SEQ_W(8)) ifc4 ();

  assign ifc4.in_first__RDY  = ifc.in_first__RDY;
  assign ifc4.in_first       = ifc.in_first;
  assign ifc4.in_deq__RDY    = ifc.in_deq__RDY;
  assign ifc4.ind_heard__RDY = ifc.ind_heard__RDY;

  echo_responder #(.SEQ_W(8), .DELAY_W(4), .CNT_W(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (ifc.slave),
    .cfg_delay (cfgDelay),
    .count     (count),
    .busy      (busy)
  );

  echo_responder #(.SEQ_W(8), .DELAY_W(4), .CNT_W(4)) dut4 (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (ifc4.slave),
    .cfg_delay (cfgDelay),
    .count     (count4),
    .busy      (busy4)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic [31:0] word);
    ifc.in_first__RDY = rdy;
    ifc.in_first      = word;
  endtask

  task automatic expectWord(input logic [31:0] word);
    sbQ.push_back({word, expSeq});
    expSeq = expSeq + 8'd1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  // Every indication must match the oldest outstanding expectation.
  always @(negedge CLK) begin : monitor
    logic [39:0] e;
    if (ifc.ind_heard__ENA === 1'b1) begin
      checkOutput("fire_expected", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        checkOutput("heard_v", ifc.ind_heard_v, e[39:8]);
        checkOutput("heard_seq", 32'(ifc.ind_heard_seq), 32'(e[7:0]));
      end
    end
  end

  initial begin
    RST                = 1'b1;
    cfgDelay           = 4'd0;
    ifc.in_first__RDY  = 1'b0;
    ifc.in_first       = 32'd0;
    ifc.in_deq__RDY    = 1'b1;
    ifc.ind_heard__RDY = 1'b1;
    expSeq             = 8'd0;

    // Reset: FIFO ready must not leak a pop while RST is high.
    tick();
    tick();
    applyStimulus(1'b1, 32'h1234_5678);
    settle();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_deq", 32'(ifc.in_deq__ENA), 32'd0);
    checkOutput("rst_ena", 32'(ifc.ind_heard__ENA), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    tick();
    RST = 1'b0;

    // Single word, zero delay.
    applyStimulus(1'b1, 32'hDEAD_BEEF);
    expectWord(32'hDEAD_BEEF);
    settle();
    checkOutput("t1_deq", 32'(ifc.in_deq__ENA), 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0);
    settle();
    checkOutput("t1_fire", 32'(ifc.ind_heard__ENA), 32'd1);
    tick();
    settle();
    checkOutput("t1_count", 32'(count), 32'd1);
    checkOutput("t1_idle", 32'(busy), 32'd0);
    tick();

    // Delay of 3 sampled at capture; a later change to 0 must not shorten the hold.
    cfgDelay = 4'd3;
    applyStimulus(1'b1, 32'h0000_0011);
    expectWord(32'h0000_0011);
    settle();
    checkOutput("t2_deq0", 32'(ifc.in_deq__ENA), 32'd1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 1) cfgDelay = 4'd0;
      applyStimulus(1'b1, 32'h0000_0022);
      settle();
      checkOutput("t2_busy", 32'(busy), 32'd1);
      checkOutput("t2_nodeq", 32'(ifc.in_deq__ENA), 32'd0);
      checkOutput("t2_noena", 32'(ifc.ind_heard__ENA), 32'd0);
      tick();
    end
    expectWord(32'h0000_0022);
    settle();
    checkOutput("t2_busy4", 32'(busy), 32'd1);
    checkOutput("t2_fire4", 32'(ifc.ind_heard__ENA), 32'd1);
    checkOutput("t2_deq4", 32'(ifc.in_deq__ENA), 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0);
    settle();
    checkOutput("t2_fire5", 32'(ifc.ind_heard__ENA), 32'd1);
    checkOutput("t2_count5", 32'(count), 32'd2);
    tick();
    settle();
    checkOutput("t2_count6", 32'(count), 32'd3);
    checkOutput("t2_idle", 32'(busy), 32'd0);
    tick();

    // Sink stall for 5 cycles holds everything, including the upstream pop.
    ifc.ind_heard__RDY = 1'b0;
    applyStimulus(1'b1, 32'hA5A5_A5A5);
    expectWord(32'hA5A5_A5A5);
    settle();
    checkOutput("t3_deq0", 32'(ifc.in_deq__ENA), 32'd1);
    tick();
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b1, 32'h5A5A_5A5A);
      settle();
      checkOutput("t3_noena", 32'(ifc.ind_heard__ENA), 32'd0);
      checkOutput("t3_nodeq", 32'(ifc.in_deq__ENA), 32'd0);
      checkOutput("t3_v", ifc.ind_heard_v, 32'hA5A5_A5A5);
      checkOutput("t3_seq", 32'(ifc.ind_heard_seq), 32'd3);
      checkOutput("t3_count", 32'(count), 32'd3);
      tick();
    end
    ifc.ind_heard__RDY = 1'b1;
    expectWord(32'h5A5A_5A5A);
    settle();
    checkOutput("t3_fire6", 32'(ifc.ind_heard__ENA), 32'd1);
    checkOutput("t3_deq6", 32'(ifc.in_deq__ENA), 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0);
    settle();
    checkOutput("t3_count7", 32'(count), 32'd4);
    tick();
    settle();
    checkOutput("t3_count8", 32'(count), 32'd5);
    tick();

    // Fresh reset, then three back-to-back words at full rate.
    RST = 1'b1;
    applyStimulus(1'b0, 32'd0);
    tick();
    RST    = 1'b0;
    expSeq = 8'd0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        applyStimulus(1'b1, 32'(k + 1));
        expectWord(32'(k + 1));
      end else begin
        applyStimulus(1'b0, 32'd0);
      end
      settle();
      if (k == 0) checkOutput("t4_count0", 32'(count), 32'd0);
      if (k < 3) checkOutput("t4_deq", 32'(ifc.in_deq__ENA), 32'd1);
      if (k >= 1) checkOutput("t4_fire", 32'(ifc.ind_heard__ENA), 32'd1);
      tick();
    end
    settle();
    checkOutput("t4_count", 32'(count), 32'd3);
    checkOutput("t4_idle", 32'(busy), 32'd0);
    tick();

    // 257 messages: seq wraps to 0 on the last one; the 4-bit counter pins at 15.
    RST = 1'b1;
    tick();
    RST    = 1'b0;
    expSeq = 8'd0;
    for (int i = 0; i <= 257; i++) begin
      if (i < 257) begin
        applyStimulus(1'b1, 32'h1000_0000 + 32'(i));
        expectWord(32'h1000_0000 + 32'(i));
      end else begin
        applyStimulus(1'b0, 32'd0);
      end
      settle();
      if (i == 15) checkOutput("t5_cnt4_14", 32'(count4), 32'd14);
      if (i == 16) checkOutput("t5_cnt4_15", 32'(count4), 32'd15);
      if (i == 17) checkOutput("t5_cnt4_hold", 32'(count4), 32'd15);
      if (i == 100) checkOutput("t5_count100", 32'(count), 32'd99);
      tick();
    end
    settle();
    checkOutput("t5_count", 32'(count), 32'd257);
    checkOutput("t5_cnt4_end", 32'(count4), 32'd15);
    checkOutput("t5_busy4", 32'(busy4), 32'd0);
    tick();

    // Reset while holding a word: that word is dropped and numbering restarts.
    cfgDelay = 4'd5;
    applyStimulus(1'b1, 32'h0000_0077);
    settle();
    checkOutput("t6_deq0", 32'(ifc.in_deq__ENA), 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0);
    settle();
    checkOutput("t6_hold", 32'(busy), 32'd1);
    tick();
    RST = 1'b1;
    applyStimulus(1'b1, 32'h0000_0099);
    settle();
    checkOutput("t6_rst_deq", 32'(ifc.in_deq__ENA), 32'd0);
    checkOutput("t6_rst_ena", 32'(ifc.ind_heard__ENA), 32'd0);
    tick();
    RST      = 1'b0;
    expSeq   = 8'd0;
    cfgDelay = 4'd0;
    applyStimulus(1'b1, 32'h0000_0088);
    expectWord(32'h0000_0088);
    settle();
    checkOutput("t6_idle", 32'(busy), 32'd0);
    checkOutput("t6_count0", 32'(count), 32'd0);
    checkOutput("t6_deq", 32'(ifc.in_deq__ENA), 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0);
    settle();
    checkOutput("t6_fire", 32'(ifc.ind_heard__ENA), 32'd1);
    tick();
    settle();
    checkOutput("t6_count1", 32'(count), 32'd1);
    tick();
    for (int c = 0; c < 8; c++) begin
      settle();
      checkOutput("t6_quiet", 32'(ifc.ind_heard__ENA), 32'd0);
      tick();
    end

    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
